float_mult_pipe: RTL and testbench

FLOAT_MULT_PIPE -- requirements
Module: float_mult_pipe

---
 rtl/float_mult_pipe.sv | 192 +++++++++++++++++++
 tb/tb_float_mult_pipe.sv | 291 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/float_mult_pipe.sv
// float_mult_pipe: three-stage pipelined floating-point multiplier, subnormals flushed to zero.
// Define FLOAT_MULT_PIPE_ROUND_EN for round-to-nearest-even; otherwise the result truncates.
module float_mult_pipe #(
   parameter  int EXP_W = 8,
   parameter  int MAN_W = 23,
   localparam int W     = 1 + EXP_W + MAN_W
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         in_valid,
   output logic         in_ready,
   input  logic [W-1:0] floatA,
   input  logic [W-1:0] floatB,
   output logic         out_valid,
   input  logic         out_ready,
   output logic [W-1:0] product,
   output logic [3:0]   flags
);

   localparam int MW = MAN_W + 1;
   localparam int PW = 2 * MW;
   localparam int EW = EXP_W + 2;
`ifdef FLOAT_MULT_PIPE_ROUND_EN
   localparam int TW = MAN_W + 4;
`else
   localparam int TW = MAN_W + 2;
`endif
   localparam logic signed [EW-1:0] BIAS     = EW'((1 << (EXP_W - 1)) - 1);
   localparam logic signed [EW-1:0] EXP_MAX  = EW'((1 << EXP_W) - 1);
   localparam logic signed [EW-1:0] EXP_ZERO = '0;

   logic en;

   logic             s1Valid_q, s1Sign_q, s1Nan_q, s1Inf_q, s1Zero_q;
   logic [EXP_W-1:0] s1ExpA_q, s1ExpB_q;
   logic [MW-1:0]    s1MantA_q, s1MantB_q;
   logic             s1Nan_d, s1Inf_d, s1Zero_d;

   logic             s2Valid_q, s2Sign_q, s2Nan_q, s2Inf_q, s2Zero_q;
   logic [EW-1:0]    s2Exp_q, s2Exp_d;
   logic [TW-1:0]    s2Top_q, s2Top_d;

   logic             outValid_q;
   logic [W-1:0]     product_q, product_d;
   logic [3:0]       flags_q, flags_d;

   logic [EXP_W-1:0] expA, expB;
   logic [MAN_W-1:0] fracA, fracB;
   logic             nanA, nanB, infA, infB, zeroA, zeroB;

   // The whole pipeline stalls together whenever a finished result is waiting.
   assign en        = !outValid_q | out_ready;
   assign in_ready  = en;
   assign out_valid = outValid_q;
   assign product   = product_q;
   assign flags     = flags_q;

   assign expA  = floatA[W-2 -: EXP_W];
   assign expB  = floatB[W-2 -: EXP_W];
   assign fracA = floatA[MAN_W-1:0];
   assign fracB = floatB[MAN_W-1:0];
   assign nanA  = (&expA) & (|fracA);
   assign nanB  = (&expB) & (|fracB);
   assign infA  = (&expA) & ~(|fracA);
   assign infB  = (&expB) & ~(|fracB);
   assign zeroA = ~(|expA);
   assign zeroB = ~(|expB);

   assign s1Nan_d  = nanA | nanB | ((infA | infB) & (zeroA | zeroB));
   assign s1Inf_d  = infA | infB;
   assign s1Zero_d = zeroA | zeroB;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         s1Valid_q <= 1'b0;
         s1Sign_q  <= 1'b0;
         s1Nan_q   <= 1'b0;
         s1Inf_q   <= 1'b0;
         s1Zero_q  <= 1'b0;
         s1ExpA_q  <= '0;
         s1ExpB_q  <= '0;
         s1MantA_q <= '0;
         s1MantB_q <= '0;
      end else if (en) begin
         s1Valid_q <= in_valid;
         s1Sign_q  <= floatA[W-1] ^ floatB[W-1];
         s1Nan_q   <= s1Nan_d;
         s1Inf_q   <= s1Inf_d;
         s1Zero_q  <= s1Zero_d;
         s1ExpA_q  <= expA;
         s1ExpB_q  <= expB;
         s1MantA_q <= {1'b1, fracA};
         s1MantB_q <= {1'b1, fracB};
      end
   end

   assign s2Exp_d = $signed({2'b00, s1ExpA_q}) + $signed({2'b00, s1ExpB_q}) - BIAS;

`ifdef FLOAT_MULT_PIPE_ROUND_EN
   logic [PW-1:0] prodFull;
   logic          s2Sticky_q, s2Sticky_d;

   assign prodFull   = PW'(s1MantA_q) * PW'(s1MantB_q);
   assign s2Top_d    = prodFull[PW-1 -: TW];
   assign s2Sticky_d = |prodFull[PW-TW-1:0];

   always_ff @(posedge clk or negedge reset) begin
      if (!reset)
         s2Sticky_q <= 1'b0;
      else if (en)
         s2Sticky_q <= s2Sticky_d;
   end
`else
   // Only the leading bits survive truncation, so the low product bits are never kept.
   assign s2Top_d = TW'((PW'(s1MantA_q) * PW'(s1MantB_q)) >> (PW - TW));
`endif

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         s2Valid_q <= 1'b0;
         s2Sign_q  <= 1'b0;
         s2Nan_q   <= 1'b0;
         s2Inf_q   <= 1'b0;
         s2Zero_q  <= 1'b0;
         s2Exp_q   <= '0;
         s2Top_q   <= '0;
      end else if (en) begin
         s2Valid_q <= s1Valid_q;
         s2Sign_q  <= s1Sign_q;
         s2Nan_q   <= s1Nan_q;
         s2Inf_q   <= s1Inf_q;
         s2Zero_q  <= s1Zero_q;
         s2Exp_q   <= s2Exp_d;
         s2Top_q   <= s2Top_d;
      end
   end

   logic              hi;
   logic [MAN_W-1:0]  mantTrunc;
   logic [MW-1:0]     mantRnd;
   logic signed [EW-1:0] expAdj;
`ifdef FLOAT_MULT_PIPE_ROUND_EN
   logic guardBit, roundBit, stickyBit, roundUp;
`endif

   // A product in [2,4) is renormalised, and a rounding carry bumps the exponent once more.
   always_comb begin
      hi        = s2Top_q[TW-1];
      mantTrunc = hi ? s2Top_q[TW-2 -: MAN_W] : s2Top_q[TW-3 -: MAN_W];
`ifdef FLOAT_MULT_PIPE_ROUND_EN
      guardBit  = hi ? s2Top_q[2] : s2Top_q[1];
      roundBit  = hi ? s2Top_q[1] : s2Top_q[0];
      stickyBit = s2Sticky_q | (hi & s2Top_q[0]);
      roundUp   = guardBit & (roundBit | stickyBit | mantTrunc[0]);
      mantRnd   = {1'b0, mantTrunc} + MW'(roundUp);
`else
      mantRnd   = {1'b0, mantTrunc};
`endif
      expAdj    = s2Exp_q + $signed({{(EW-1){1'b0}}, hi})
                          + $signed({{(EW-1){1'b0}}, mantRnd[MAN_W]});
      product_d = {s2Sign_q, expAdj[EXP_W-1:0], mantRnd[MAN_W-1:0]};
      flags_d   = 4'b0000;
      if (s2Nan_q) begin
         product_d = {s2Sign_q, {EXP_W{1'b1}}, 1'b1, {(MAN_W-1){1'b0}}};
         flags_d   = 4'b1000;
      end else if (s2Inf_q) begin
         product_d = {s2Sign_q, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
      end else if (s2Zero_q) begin
         product_d = {s2Sign_q, {(W-1){1'b0}}};
         flags_d   = 4'b0001;
      end else if (expAdj >= EXP_MAX) begin
         product_d = {s2Sign_q, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
         flags_d   = 4'b0100;
      end else if (expAdj <= EXP_ZERO) begin
         product_d = {s2Sign_q, {(W-1){1'b0}}};
         flags_d   = 4'b0011;
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         outValid_q <= 1'b0;
         product_q  <= '0;
         flags_q    <= '0;
      end else if (en) begin
         outValid_q <= s2Valid_q;
         product_q  <= product_d;
         flags_q    <= flags_d;
      end
   end

endmodule

// File: tb/tb_float_mult_pipe.sv
// tb_float_mult_pipe: scoreboard bench for float_mult_pipe with default parameters.
// Expected {flags, product} pairs are queued on input acceptance and popped on output transfer.
module tb_float_mult_pipe;

   logic        clk = 1'b0;
   logic        reset;
   logic        in_valid;
   logic        in_ready;
   logic [31:0] floatA;
   logic [31:0] floatB;
   logic        out_valid;
   logic        out_ready;
   logic [31:0] product;
   logic [3:0]  flags;

   logic [35:0] expQ[$];
   int          checks   = 0;
   int          failures = 0;

   // Free-running 10-unit clock.
   always #5 clk = ~clk;

   float_mult_pipe dut (
      .clk(clk),
      .reset(reset),
      .in_valid(in_valid),
      .in_ready(in_ready),
      .floatA(floatA),
      .floatB(floatB),
      .out_valid(out_valid),
      .out_ready(out_ready),
      .product(product),
      .flags(flags)
   );

   // Called at a falling edge: drives inputs, samples pre-edge handshake state, then advances one cycle.
   task automatic stepCycle(input logic v, input logic [31:0] a, input logic [31:0] b,
                            input logic [35:0] expVal, input logic rdy,
                            output logic acc, output logic fired, output logic obsReady,
                            output logic obsValid, output logic [35:0] obs);
      in_valid  = v;
      floatA    = a;
      floatB    = b;
      out_ready = rdy;
      #1;
      acc      = in_valid & in_ready;
      fired    = out_valid & out_ready;
      obsReady = in_ready;
      obsValid = out_valid;
      obs      = {flags, product};
      if (acc) expQ.push_back(expVal);
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic test_reset();
      reset     = 1'b1;
      in_valid  = 1'b0;
      floatA    = '0;
      floatB    = '0;
      out_ready = 1'b1;
      #2 reset  = 1'b0;
      @(negedge clk);
      #1;
      checks++;
      if (out_valid !== 1'b0) begin failures++; $display("[TB] FAIL reset_out_valid got %b expected 0", out_valid); end
      checks++;
      if (in_ready !== 1'b1) begin failures++; $display("[TB] FAIL reset_in_ready got %b expected 1", in_ready); end
      checks++;
      if (product !== 32'h0) begin failures++; $display("[TB] FAIL reset_product got %h expected 00000000", product); end
      checks++;
      if (flags !== 4'h0) begin failures++; $display("[TB] FAIL reset_flags got %b expected 0000", flags); end
      @(negedge clk);
      reset = 1'b1;
   endtask

   task automatic test_basic();
      logic [31:0] va[2];
      logic [31:0] vb[2];
      logic [35:0] ve[2];
      logic        acc, fired, r, v, got;
      logic [35:0] obs, e;
      va = '{32'h40000000, 32'hC0000000};
      vb = '{32'h40400000, 32'h40400000};
      ve = '{{4'b0000, 32'h40C00000}, {4'b0000, 32'hC0C00000}};
      for (int k = 0; k < 2; k++) begin
         got = 1'b0;
         stepCycle(1'b1, va[k], vb[k], ve[k], 1'b1, acc, fired, r, v, obs);
         checks++;
         if (acc !== 1'b1) begin failures++; $display("[TB] FAIL basic_accept[%0d] got %b expected 1", k, acc); end
         for (int c = 1; c <= 8 && !got; c++) begin
            stepCycle(1'b0, '0, '0, '0, 1'b1, acc, fired, r, v, obs);
            if (fired && expQ.size() > 0) begin
               got = 1'b1;
               checks++;
               if (c != 3) begin failures++; $display("[TB] FAIL basic_latency[%0d] got %0d expected 3", k, c); end
               e = expQ.pop_front();
               checks++;
               if (obs !== e) begin failures++; $display("[TB] FAIL basic_result[%0d] got %h expected %h", k, obs, e); end
            end
         end
         checks++;
         if (!got) begin failures++; $display("[TB] FAIL basic_timeout[%0d] got no output expected one", k); end
         expQ.delete();
      end
   endtask

   task automatic test_special();
      logic [31:0] va[8];
      logic [31:0] vb[8];
      logic [35:0] ve[8];
      logic        acc, fired, r, v;
      logic [35:0] obs, e;
      int          idx = 0;
      int          n   = 0;
      int          k;
      va = '{32'h39D844D0, 32'h7F800000, 32'h7F000000, 32'h00800000,
             32'hFF800000, 32'h80000000, 32'h00000001, 32'h7FC00001};
      vb = '{32'h00000000, 32'h00000000, 32'h7F000000, 32'h3F000000,
             32'h40000000, 32'h3F800000, 32'h3F800000, 32'hBF800000};
      ve = '{{4'b0001, 32'h00000000}, {4'b1000, 32'h7FC00000},
             {4'b0100, 32'h7F800000}, {4'b0011, 32'h00000000},
             {4'b0000, 32'hFF800000}, {4'b0001, 32'h80000000},
             {4'b0001, 32'h00000000}, {4'b1000, 32'hFFC00000}};
      for (int c = 0; c < 60 && (idx < 8 || expQ.size() > 0); c++) begin
         k = (idx < 8) ? idx : 0;
         stepCycle(idx < 8, va[k], vb[k], ve[k], 1'b1, acc, fired, r, v, obs);
         if (acc) idx++;
         if (fired) begin
            checks++;
            if (expQ.size() == 0) begin
               failures++; $display("[TB] FAIL special_extra got %h expected no output", obs);
            end else begin
               e = expQ.pop_front();
               if (obs !== e) begin failures++; $display("[TB] FAIL special[%0d] got %h expected %h", n, obs, e); end
            end
            n++;
         end
      end
      checks++;
      if (n != 8 || expQ.size() != 0) begin failures++; $display("[TB] FAIL special_count got %0d expected 8", n); end
      expQ.delete();
   endtask

   task automatic test_rounding();
      logic [31:0] va[2];
      logic [31:0] vb[2];
      logic [35:0] ve[2];
      logic        acc, fired, r, v;
      logic [35:0] obs, e;
      int          idx = 0;
      int          n   = 0;
      int          k;
      va = '{32'h3F800001, 32'h3F800001};
      vb = '{32'h3FC00000, 32'h3F800001};
`ifdef FLOAT_MULT_PIPE_ROUND_EN
      ve = '{{4'b0000, 32'h3FC00002}, {4'b0000, 32'h3F800002}};
`else
      ve = '{{4'b0000, 32'h3FC00001}, {4'b0000, 32'h3F800002}};
`endif
      for (int c = 0; c < 30 && (idx < 2 || expQ.size() > 0); c++) begin
         k = (idx < 2) ? idx : 0;
         stepCycle(idx < 2, va[k], vb[k], ve[k], 1'b1, acc, fired, r, v, obs);
         if (acc) idx++;
         if (fired) begin
            checks++;
            if (expQ.size() == 0) begin
               failures++; $display("[TB] FAIL rounding_extra got %h expected no output", obs);
            end else begin
               e = expQ.pop_front();
               if (obs !== e) begin failures++; $display("[TB] FAIL rounding[%0d] got %h expected %h", n, obs, e); end
            end
            n++;
         end
      end
      checks++;
      if (n != 2 || expQ.size() != 0) begin failures++; $display("[TB] FAIL rounding_count got %0d expected 2", n); end
      expQ.delete();
   endtask

   task automatic test_back_to_back();
      logic [31:0] va[8];
      logic [31:0] vb[8];
      logic [35:0] ve[8];
      logic        acc, fired, r, v, rdy;
      logic [35:0] obs, e;
      int          idx   = 0;
      int          n     = 0;
      int          stall = 0;
      int          k;
      va = '{32'h3F800000, 32'h40000000, 32'h40400000, 32'h3F000000,
             32'hBF800000, 32'h40A00000, 32'h3FC00000, 32'hC0000000};
      vb = '{32'h3F800000, 32'h40000000, 32'h40400000, 32'h40800000,
             32'h40A00000, 32'h40A00000, 32'h3FC00000, 32'hC0400000};
      ve = '{{4'b0, 32'h3F800000}, {4'b0, 32'h40800000}, {4'b0, 32'h41100000}, {4'b0, 32'h40000000},
             {4'b0, 32'hC0A00000}, {4'b0, 32'h41C80000}, {4'b0, 32'h40100000}, {4'b0, 32'h40C00000}};
      for (int c = 0; c < 60 && (idx < 8 || expQ.size() > 0); c++) begin
         k   = (idx < 8) ? idx : 0;
         rdy = !(c >= 4 && c < 8);
         stepCycle(idx < 8, va[k], vb[k], ve[k], rdy, acc, fired, r, v, obs);
         if (acc) idx++;
         if (v && !rdy) begin
            stall++;
            checks++;
            if (r !== 1'b0) begin failures++; $display("[TB] FAIL stall_in_ready cycle %0d got %b expected 0", c, r); end
            checks++;
            if (expQ.size() == 0 || obs !== expQ[0]) begin
               failures++; $display("[TB] FAIL stall_hold cycle %0d got %h expected head of queue", c, obs);
            end
         end
         if (fired) begin
            checks++;
            if (expQ.size() == 0) begin
               failures++; $display("[TB] FAIL b2b_extra got %h expected no output", obs);
            end else begin
               e = expQ.pop_front();
               if (obs !== e) begin failures++; $display("[TB] FAIL b2b[%0d] got %h expected %h", n, obs, e); end
            end
            n++;
         end
      end
      checks++;
      if (n != 8 || expQ.size() != 0) begin failures++; $display("[TB] FAIL b2b_count got %0d expected 8", n); end
      checks++;
      if (stall != 4) begin failures++; $display("[TB] FAIL b2b_stall_cycles got %0d expected 4", stall); end
      expQ.delete();
   endtask

   task automatic test_reset_midflight();
      logic        acc, fired, r, v, got;
      logic [35:0] obs, e;
      int          stale = 0;
      for (int k = 0; k < 3; k++)
         stepCycle(1'b1, 32'h40000000, 32'h40400000, {4'b0, 32'h40C00000}, 1'b1, acc, fired, r, v, obs);
      in_valid = 1'b0;
      reset    = 1'b0;
      #1;
      checks++;
      if (out_valid !== 1'b0) begin failures++; $display("[TB] FAIL midreset_out_valid got %b expected 0", out_valid); end
      checks++;
      if ({flags, product} !== 36'h0) begin failures++; $display("[TB] FAIL midreset_product got %h expected 0", {flags, product}); end
      @(posedge clk);
      @(negedge clk);
      #1;
      checks++;
      if (out_valid !== 1'b0) begin failures++; $display("[TB] FAIL midreset_hold got %b expected 0", out_valid); end
      expQ.delete();
      reset = 1'b1;
      for (int c = 0; c < 6; c++) begin
         stepCycle(1'b0, '0, '0, '0, 1'b1, acc, fired, r, v, obs);
         if (v) stale++;
      end
      checks++;
      if (stale != 0) begin failures++; $display("[TB] FAIL midreset_stale got %0d expected 0", stale); end
      got = 1'b0;
      stepCycle(1'b1, 32'h3F800000, 32'h40000000, {4'b0, 32'h40000000}, 1'b1, acc, fired, r, v, obs);
      for (int c = 1; c <= 8 && !got; c++) begin
         stepCycle(1'b0, '0, '0, '0, 1'b1, acc, fired, r, v, obs);
         if (fired && expQ.size() > 0) begin
            got = 1'b1;
            checks++;
            if (c != 3) begin failures++; $display("[TB] FAIL midreset_latency got %0d expected 3", c); end
            e = expQ.pop_front();
            checks++;
            if (obs !== e) begin failures++; $display("[TB] FAIL midreset_result got %h expected %h", obs, e); end
         end
      end
      checks++;
      if (!got) begin failures++; $display("[TB] FAIL midreset_timeout got no output expected one"); end
      expQ.delete();
   endtask

   initial begin
      test_reset();
      test_basic();
      test_special();
      test_rounding();
      test_back_to_back();
      test_reset_midflight();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   // Last-resort guard so a wedged run still terminates.
   initial begin
      #200000;
      $display("[TB] FAIL watchdog got timeout expected completion");
      $fatal(1, "[TB] watchdog expired");
   end

endmodule
